// File: rtl/vga_timing_gen_pkg.sv
// Shared timing defaults and lock-qualifier state encoding for the pixel timing generator.
package vga_timing_gen_pkg;

  // 640x480@60 on a 25 MHz pixel clock
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_LOCK_WAIT = 1024;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } lock_state_e;

endpackage

// File: rtl/vga_timing_gen_lock_qualifier.sv
// Synchronises the PLL lock flag and requires it to stay high LOCK_WAIT cycles before enabling timing.
module lock_qualifier
  import vga_timing_gen_pkg::*;
#(
  parameter int LOCK_WAIT = DEF_LOCK_WAIT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pll_locked,
  output logic run_en
);

  localparam int CW = $clog2(LOCK_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_WAIT);

  logic [1:0]    sync_q;
  logic          lock_s;
  lock_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign lock_s = sync_q[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b00;
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], pll_locked};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: if (lock_s) begin
        state_d = SETTLE;
        cnt_d   = CW'(1);
      end
      SETTLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: if (!lock_s) begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  assign run_en = (state_q == RUN);

endmodule

// File: rtl/vga_timing_gen.sv
// Video timing generator: H/V counters gated by the qualified PLL lock, with registered
// sync/data-enable/coordinate outputs that all share one cycle of latency.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int LOCK_WAIT = DEF_LOCK_WAIT,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          pll_locked,
  output logic          running,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic          run_en;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  logic          running_d, hsync_d, vsync_d, de_d, line_start_d, frame_start_d;
  logic [HW-1:0] x_d;
  logic [VW-1:0] y_d;

  lock_qualifier #(.LOCK_WAIT(LOCK_WAIT)) u_lock_qualifier (
    .clock      (clock),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .run_en     (run_en)
  );

  // Counters sit at the origin whenever timing is not running, so RUN always starts at (0,0).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run_en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  always_comb begin
    running_d     = 1'b0;
    de_d          = 1'b0;
    hsync_d       = ~HS_POL;
    vsync_d       = ~VS_POL;
    x_d           = '0;
    y_d           = '0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (run_en) begin
      running_d     = 1'b1;
      de_d          = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
      hsync_d       = (h_cnt >= HS_BEG && h_cnt < HS_END) ? HS_POL : ~HS_POL;
      vsync_d       = (v_cnt >= VS_BEG && v_cnt < VS_END) ? VS_POL : ~VS_POL;
      x_d           = h_cnt;
      y_d           = v_cnt;
      line_start_d  = (h_cnt == '0);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      running     <= 1'b0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      running     <= running_d;
      de          <= de_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      x           <= x_d;
      y           <= y_d;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
    end
  end

endmodule
